// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// A launch computes the result up front, holds busy for a fixed latency and then commits HI/LO.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  op,
  input  logic        req,
  input  logic        d_mdu,
  output logic        busy,
  output logic        stall,
  output logic [31:0] res
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ?
                                       $clog2(MAX_CYCLES + 1) : 4;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {StIdle, StRun} state_e;

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [31:0]      r_hi, w_hi_d;
  logic [31:0]      r_lo, w_lo_d;
  logic [31:0]      r_pend_hi, w_pend_hi_d;
  logic [31:0]      r_pend_lo, w_pend_lo_d;
  logic             r_pend_wr, w_pend_wr_d;

  // Products: operands are explicitly extended so the low 64 bits are the exact product.
  logic [63:0] w_smul;
  logic [63:0] w_umul;
  assign w_smul = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign w_umul = {32'd0, A} * {32'd0, B};

  // One shared unsigned divider; signed division runs on magnitudes and fixes signs afterwards,
  // which also yields LO=0x80000000, HI=0 for the 0x80000000 / -1 overflow case.
  logic        w_signed_div;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_num;
  logic [31:0] w_den;
  logic [31:0] w_den_safe;
  logic [31:0] w_uquo;
  logic [31:0] w_urem;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_div_zero;

  assign w_signed_div = (op == OP_DIV);
  assign w_a_mag      = A[31] ? (32'd0 - A) : A;
  assign w_b_mag      = B[31] ? (32'd0 - B) : B;
  assign w_num        = w_signed_div ? w_a_mag : A;
  assign w_den        = w_signed_div ? w_b_mag : B;
  assign w_div_zero   = (B == 32'd0);
  assign w_den_safe   = w_div_zero ? 32'd1 : w_den;
  assign w_uquo       = w_num / w_den_safe;
  assign w_urem       = w_num % w_den_safe;
  assign w_quo        = (w_signed_div && (A[31] ^ B[31])) ? (32'd0 - w_uquo) : w_uquo;
  assign w_rem        = (w_signed_div && A[31]) ? (32'd0 - w_urem) : w_urem;

  logic w_is_mdiv;
  assign w_is_mdiv = (op >= OP_MULT) && (op <= OP_DIVU);

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_hi_d      = r_hi;
    w_lo_d      = r_lo;
    w_pend_hi_d = r_pend_hi;
    w_pend_lo_d = r_pend_lo;
    w_pend_wr_d = r_pend_wr;
    unique case (r_state)
      StIdle: begin
        if (req) begin
          case (op)
            OP_MULT: begin
              {w_pend_hi_d, w_pend_lo_d} = w_smul;
              w_pend_wr_d = 1'b1;
              w_cnt_d     = CNT_W'(MULT_CYCLES);
              w_state_d   = StRun;
            end
            OP_MULTU: begin
              {w_pend_hi_d, w_pend_lo_d} = w_umul;
              w_pend_wr_d = 1'b1;
              w_cnt_d     = CNT_W'(MULT_CYCLES);
              w_state_d   = StRun;
            end
            OP_DIV, OP_DIVU: begin
              w_pend_hi_d = w_rem;
              w_pend_lo_d = w_quo;
              // Divide by zero still burns the full latency but leaves HI/LO alone.
              w_pend_wr_d = !w_div_zero;
              w_cnt_d     = CNT_W'(DIV_CYCLES);
              w_state_d   = StRun;
            end
            OP_MTHI: w_hi_d = A;
            OP_MTLO: w_lo_d = A;
            default: ;
          endcase
        end
      end
      StRun: begin
        w_cnt_d = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          if (r_pend_wr) begin
            w_hi_d = r_pend_hi;
            w_lo_d = r_pend_lo;
          end
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_hi      <= w_hi_d;
      r_lo      <= w_lo_d;
      r_pend_hi <= w_pend_hi_d;
      r_pend_lo <= w_pend_lo_d;
      r_pend_wr <= w_pend_wr_d;
    end
  end

  assign busy  = (r_state == StRun);
  assign stall = d_mdu & (busy | (req & w_is_mdiv));

  always_comb begin
    res = 32'd0;
    if (op == OP_MFHI) res = r_hi;
    else if (op == OP_MFLO) res = r_lo;
  end

endmodule
